mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that responds on the core's data-side memory port, in place of or alongside the BRAM.
- Uses the same protocol as the BRAM: read address in, registered read data one cycle later, and a write port with byte enables.
- The core writes bytes into a TX FIFO; a baud-rate FSM serialises them 8N1, LSB first, on the tx pin.
- Provides console/debug output for programs running on the core.

---
 rtl/mmio_uart_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// BRAM-style memory-mapped UART transmitter: TX FIFO feeding an 8N1 LSB-first serialiser.
// Define MMIO_UART_TX_PARITY_EN to add an optional even/odd parity bit controlled from DIV[17:16].
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  byte_en,
    output logic        tx,
    output logic        tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // Write port: a write is taken on every rising edge where wr_en is high; there is no
    // ready back-pressure, so unmapped writes and pushes into a full FIFO are simply dropped.
    logic        wr_hit, rd_hit;
    logic        push_req, push, pop, ovf_clr, div_wr;
    logic        full, empty, ovf;
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [7:0]  fifo_head;
    logic [15:0] div;
    logic [31:0] div_rd, status_rd, rd_next;

    assign wr_hit   = wr_en && (wr_addr[31:4] == BASE_ADDR[31:4]);
    assign rd_hit   = (addr[31:4] == BASE_ADDR[31:4]);
    assign push_req = wr_hit && (wr_addr[3:2] == 2'd0) && byte_en[0];
    assign ovf_clr  = wr_hit && (wr_addr[3:2] == 2'd1) && byte_en[0] && wr_data[3];
    assign div_wr   = wr_hit && (wr_addr[3:2] == 2'd2);

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == DEPTH_L);
    assign empty     = (count == '0);
    assign push      = push_req && !full;
    assign fifo_head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            // A drop in the same cycle as a clear leaves OVF set.
            if (push_req && full) ovf <= 1'b1;
            else if (ovf_clr)     ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= DEFAULT_DIV;
        end else if (div_wr) begin
            if (byte_en[0]) div[7:0]  <= wr_data[7:0];
            if (byte_en[1]) div[15:8] <= wr_data[15:8];
        end
    end

`ifdef MMIO_UART_TX_PARITY_EN
    logic par_en, par_odd, par_on_q, par_bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en    <= 1'b0;
            par_odd   <= 1'b0;
            par_on_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            if (div_wr && byte_en[2]) begin
                par_en  <= wr_data[16];
                par_odd <= wr_data[17];
            end
            // Parity settings are frozen per frame, like div_eff.
            if (pop) begin
                par_on_q  <= par_en;
                par_bit_q <= (^fifo_head) ^ par_odd;
            end
        end
    end

    assign div_rd = {14'b0, par_odd, par_en, div};
`else
    assign div_rd = {16'b0, div};
`endif

    assign status_rd = {16'b0, 8'(count), 4'b0, ovf, tx_busy, empty, full};

    always_comb begin
        rd_next = '0;
        if (rd_hit) begin
            case (addr[3:2])
                2'd1:    rd_next = status_rd;
                2'd2:    rd_next = div_rd;
                default: rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= rd_next;
    end

    state_t      state, state_d;
    logic [7:0]  shift, shift_d;
    logic [15:0] baud, baud_d, div_eff, div_eff_d;
    logic [2:0]  bit_cnt, bit_d;
    logic        tx_d, load, tx_idle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= '0;
            baud      <= '0;
            div_eff   <= 16'd1;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            tx_idle_q <= 1'b1;
        end else begin
            state     <= state_d;
            shift     <= shift_d;
            baud      <= baud_d;
            div_eff   <= div_eff_d;
            bit_cnt   <= bit_d;
            tx        <= tx_d;
            tx_idle_q <= (state == IDLE);
        end
    end

    // baud counts each bit period down from div_eff-1; tx is the registered line level,
    // so the wire trails the state by one cycle.
    always_comb begin
        state_d   = state;
        shift_d   = shift;
        baud_d    = baud;
        div_eff_d = div_eff;
        bit_d     = bit_cnt;
        tx_d      = 1'b1;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: load = !empty;
            START: begin
                tx_d = 1'b0;
                if (baud == '0) begin
                    baud_d  = div_eff - 16'd1;
                    state_d = DATA;
                end else begin
                    baud_d = baud - 16'd1;
                end
            end
            DATA: begin
                tx_d = shift[0];
                if (baud == '0) begin
                    baud_d  = div_eff - 16'd1;
                    shift_d = {1'b0, shift[7:1]};
                    bit_d   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = par_on_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud - 16'd1;
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: begin
                tx_d = par_bit_q;
                if (baud == '0) begin
                    baud_d  = div_eff - 16'd1;
                    state_d = STOP;
                end else begin
                    baud_d = baud - 16'd1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (baud == '0) begin
                    if (!empty) load = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    baud_d = baud - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            pop       = 1'b1;
            shift_d   = fifo_head;
            div_eff_d = (div == '0) ? 16'd1 : div;
            baud_d    = div_eff_d - 16'd1;
            bit_d     = '0;
            state_d   = START;
        end
    end

    // tx_idle_q covers the final stop-bit cycle still on the wire after the FSM returns to IDLE.
    assign tx_busy = !empty || (state != IDLE) || !tx_idle_q;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wr_addr[1:0], wr_data[31:16], byte_en[3:2]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, a serial line monitor that
// checks each frame against the expected byte queue, and directed multi-cycle sequences.
module tb_mmio_uart_tx;
    localparam logic [31:0] B = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] rd_data;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  byte_en = '0;
    logic        tx, tx_busy;

    mmio_uart_tx #(.BASE_ADDR(B), .FIFO_DEPTH(16), .DEFAULT_DIV(16'd868)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .byte_en(byte_en),
        .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        bit          do_wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        byte_en = be;
        tick();
        wr_en   = 1'b0;
        byte_en = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Line monitor: an 8N1 frame is 10 symbols of mon_div cycles each, busy high throughout.
    int         mon_div = 868;
    int         frame_div, pos, bad, idle_run, frames_done, frames_started;
    bit         in_frame, unexp;
    int         gaps[$];
    logic [9:0] fbits;
    logic [7:0] fbyte;

    initial begin
        in_frame = 0; idle_run = 0; frames_done = 0; frames_started = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                in_frame = 0;
                idle_run = 0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    in_frame  = 1;
                    pos       = 0;
                    bad       = 0;
                    frame_div = mon_div;
                    gaps.push_back(idle_run);
                    frames_started++;
                    if (exp_q.size() == 0) begin
                        unexp = 1;
                        fbits = '1;
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: got start bit expected idle line");
                    end else begin
                        unexp = 0;
                        fbyte = exp_q.pop_front();
                        fbits = {1'b1, fbyte, 1'b0};
                    end
                end
                if (in_frame) begin
                    if (tx !== fbits[pos / frame_div] || tx_busy !== 1'b1) bad++;
                    pos++;
                    if (pos == 10 * frame_div) begin
                        in_frame = 0;
                        idle_run = 0;
                        frames_done++;
                        if (!unexp) begin
                            tests++;
                            if (bad != 0) begin
                                fails++;
                                $display("FAIL frame_%0d byte %h div %0d: got %0d bad samples expected 0",
                                         frames_done, fbyte, frame_div, bad);
                            end
                        end
                    end
                end else begin
                    idle_run++;
                end
            end
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (frames_done < target) begin
            fails++;
            $display("FAIL wait_frames: got %0d frames expected %0d", frames_done, target);
            exp_q.delete();
        end
    endtask

    function automatic int gap_at(input int idx);
        return (gaps.size() > idx) ? gaps[idx] : -1;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [31:0] d;
        logic [7:0]  b;
        int          base, base_s, dv, n, lows;

        // Register access table: optional write, then a read with its expected data.
        vecs.push_back('{1'b0, 32'h0, 32'h0, 4'h0, B + 32'h4, 32'h0000_0002});
        vecs.push_back('{1'b0, 32'h0, 32'h0, 4'h0, B + 32'h8, 32'd868});
        vecs.push_back('{1'b0, 32'h0, 32'h0, 4'h0, B + 32'h0, 32'h0});
        vecs.push_back('{1'b0, 32'h0, 32'h0, 4'h0, B + 32'hC, 32'h0});
        vecs.push_back('{1'b0, 32'h0, 32'h0, 4'h0, B + 32'h10, 32'h0});
        vecs.push_back('{1'b0, 32'h0, 32'h0, 4'h0, 32'h2000_0004, 32'h0});
        vecs.push_back('{1'b1, B + 32'h8, 32'h1234_5678, 4'b0011, B + 32'h8, 32'h0000_5678});
        vecs.push_back('{1'b1, B + 32'h8, 32'h0000_00AB, 4'b0001, B + 32'h8, 32'h0000_56AB});
        vecs.push_back('{1'b1, B + 32'h8, 32'hFFFF_FFFF, 4'b1000, B + 32'h8, 32'h0000_56AB});
        vecs.push_back('{1'b1, B + 32'h8, 32'h0000_0364, 4'b0011, B + 32'h8, 32'd868});
        vecs.push_back('{1'b1, B + 32'hC, 32'hFFFF_FFFF, 4'b1111, B + 32'hC, 32'h0});
        vecs.push_back('{1'b1, B + 32'h10, 32'h0000_0041, 4'b0001, B + 32'h4, 32'h0000_0002});
        vecs.push_back('{1'b1, B, 32'h0000_0041, 4'b0010, B + 32'h4, 32'h0000_0002});
        vecs.push_back('{1'b1, 32'h0, 32'h0000_0041, 4'b1111, B + 32'h4, 32'h0000_0002});

        // Reset values
        @(posedge clk);
        #1;
        check32("reset_rd_data", rd_data, 32'h0);
        check1("reset_tx", tx, 1'b1);
        check1("reset_busy", tx_busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(vecs[i].wa, vecs[i].wd, vecs[i].be);
            rd(vecs[i].ra, d);
            check32($sformatf("vec_%0d", i), d, vecs[i].exp);
        end

        // Single frame, DIV=4
        wr(B + 32'h8, 32'd4, 4'b0011);
        mon_div = 4;
        base = frames_done;
        wr(B, 32'h0000_00A5, 4'b0001);
        exp_q.push_back(8'hA5);
        check1("busy_after_push", tx_busy, 1'b1);
        repeat (3) tick();
        rd(B + 32'h4, d);
        check32("status_mid_frame", d, 32'h0000_0006);
        wait_frames(base + 1, 200);
        check1("busy_after_stop", tx_busy, 1'b0);

        // Three back-to-back frames, DIV=2
        wr(B + 32'h8, 32'd2, 4'b0011);
        mon_div = 2;
        base = frames_done;
        base_s = frames_started;
        for (int k = 0; k < 3; k++) begin
            b = 8'h11 * 8'(k + 1);
            wr(B, {24'h0, b}, 4'b0001);
            exp_q.push_back(b);
        end
        rd(B + 32'h4, d);
        check32("status_burst", d, 32'h0000_0204);
        wait_frames(base + 3, 300);
        check32("gap_burst_1", 32'(gap_at(base_s + 1)), 32'd0);
        check32("gap_burst_2", 32'(gap_at(base_s + 2)), 32'd0);
        rd(B + 32'h4, d);
        check32("status_burst_done", d, 32'h0000_0002);

        // Overflow: 18 writes at one per cycle, first byte popped the cycle after its push
        wr(B + 32'h8, 32'd1000, 4'b0011);
        mon_div = 1000;
        base = frames_done;
        base_s = frames_started;
        for (int k = 0; k < 18; k++) begin
            b = 8'h40 + 8'(k);
            wr(B, {24'h0, b}, 4'b0001);
            if (k < 17) exp_q.push_back(b);
        end
        rd(B + 32'h4, d);
        check32("status_full_ovf", d, 32'h0000_100D);
        wr(B + 32'h4, 32'h0, 4'b0001);
        rd(B + 32'h4, d);
        check32("status_ovf_kept", d, 32'h0000_100D);
        wr(B + 32'h4, 32'h8, 4'b0001);
        rd(B + 32'h4, d);
        check32("status_ovf_clr", d, 32'h0000_1005);
        wr(B + 32'h8, 32'd2, 4'b0011);
        mon_div = 2;
        wait_frames(base + 17, 12000);
        check32("gap_ovf_1", 32'(gap_at(base_s + 1)), 32'd0);
        rd(B + 32'h4, d);
        check32("status_ovf_done", d, 32'h0000_0002);

        // Randomized bursts, DIV 0..4 (0 behaves as 1)
        for (int r = 0; r < 6; r++) begin
            dv = $urandom_range(0, 4);
            n  = $urandom_range(1, 4);
            wr(B + 32'h8, {16'($urandom_range(0, 65535)), 16'(dv)}, 4'b0011);
            mon_div = (dv == 0) ? 1 : dv;
            base = frames_done;
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                wr(B, {24'h0, b}, 4'b0001);
                exp_q.push_back(b);
            end
            wait_frames(base + n, 400);
            check1($sformatf("rand_%0d_busy", r), tx_busy, 1'b0);
        end

        // Reset in the middle of a data bit
        wr(B + 32'h8, 32'd4, 4'b0011);
        mon_div = 4;
        wr(B, 32'h0, 4'b0001);
        exp_q.push_back(8'h00);
        wr(B, 32'hFF, 4'b0001);
        exp_q.push_back(8'hFF);
        repeat (10) tick();
        check1("tx_low_in_data", tx, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check1("tx_async_reset", tx, 1'b1);
        check1("busy_async_reset", tx_busy, 1'b0);
        exp_q.delete();
        mon_div = 868;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(B + 32'h4, d);
        check32("status_after_reset", d, 32'h0000_0002);
        rd(B + 32'h8, d);
        check32("div_after_reset", d, 32'd868);
        lows = 0;
        repeat (200) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check32("no_residual_frame", 32'(lows), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
